// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the MEM stage and dmem_ctrl.
// Latency: none (wires only).
// Backpressure: req_ready stalls the requester; rsp_ready stalls the responder.
//
// Ports (signals):
//   req_valid/req_ready   request handshake
//   req_write/req_size/req_signed/req_addr/req_wdata   request payload
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata/rsp_fault   response payload
interface dmem_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory (LW/LH/LHU/LB/LBU/SW/SH/SB) with alignment/range faults.
// Latency: rsp_valid is first sampled high WAIT_CYCLES+1 edges after the acceptance edge.
// Backpressure: one request in flight; req_ready=0 outside IDLE, response held until rsp_ready.
//
// Ports:
//   sclk       clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        dmem_ctrl_if slave modport (request + response channels)
//   fault_cnt  saturating count of faulting requests (only with DMEM_FAULT_CNT_EN)
// Optional feature macro: DMEM_FAULT_CNT_EN
module dmem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH_BYTES = 1024,
  parameter int BASE_OFFSET = 0,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        sclk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  bus
`ifdef DMEM_FAULT_CNT_EN
  ,
  output logic [15:0] fault_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [31:0]       r_rdata;
  logic              r_fault;
  logic [7:0]        r_mem [DEPTH_BYTES];

  logic [ADDR_W-1:0] w_ea, w_ea1, w_ea2, w_ea3;
  logic [ADDR_W:0]   w_nbytes, w_end;
  logic              w_fault, w_accept;
  logic [7:0]        w_b0, w_b1, w_b2, w_b3;
  logic [31:0]       w_load, w_rsp_data;

  // Effective address wraps naturally at 2^ADDR_W; range check is done afterwards.
  assign w_ea  = bus.req_addr + ADDR_W'(BASE_OFFSET);
  assign w_ea1 = w_ea + ADDR_W'(1);
  assign w_ea2 = w_ea + ADDR_W'(2);
  assign w_ea3 = w_ea + ADDR_W'(3);

  always_comb begin
    w_nbytes = (ADDR_W+1)'(1);
    case (bus.req_size)
      2'b00:   w_nbytes = (ADDR_W+1)'(4);
      2'b01:   w_nbytes = (ADDR_W+1)'(2);
      default: w_nbytes = (ADDR_W+1)'(1);
    endcase
  end

  // One extra bit so ea+bytes cannot wrap before comparing with DEPTH_BYTES.
  assign w_end   = {1'b0, w_ea} + w_nbytes;
  assign w_fault = (bus.req_size == 2'b11)
                || (bus.req_size == 2'b00 && w_ea[1:0] != 2'b00)
                || (bus.req_size == 2'b01 && w_ea[0])
                || (w_end > (ADDR_W+1)'(DEPTH_BYTES));

  // rst_n gating keeps a request held during reset from touching the array.
  assign w_accept = rst_n && (r_state == S_IDLE) && bus.req_valid;

  // Lane reads may index past the array on a faulting request; the result is discarded.
  assign w_b0 = r_mem[w_ea];
  assign w_b1 = r_mem[w_ea1];
  assign w_b2 = r_mem[w_ea2];
  assign w_b3 = r_mem[w_ea3];

  always_comb begin
    w_load = 32'h0;
    if (!w_fault) begin
      case (bus.req_size)
        2'b00:   w_load = {w_b3, w_b2, w_b1, w_b0};
        2'b01:   w_load = {{16{bus.req_signed & w_b1[7]}}, w_b1, w_b0};
        2'b10:   w_load = {{24{bus.req_signed & w_b0[7]}}, w_b0};
        default: w_load = 32'h0;
      endcase
    end
  end

  assign w_rsp_data = bus.req_write ? 32'h0 : w_load;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rdata <= w_rsp_data;
        r_fault <= w_fault;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'(WAIT_CYCLES - 1)) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_fault = r_fault;

  // Array is not reset; stores commit at the acceptance edge.
  always_ff @(posedge sclk) begin
    if (w_accept && bus.req_write && !w_fault) begin
      r_mem[w_ea] <= bus.req_wdata[7:0];
      if (bus.req_size != 2'b10) r_mem[w_ea1] <= bus.req_wdata[15:8];
      if (bus.req_size == 2'b00) begin
        r_mem[w_ea2] <= bus.req_wdata[23:16];
        r_mem[w_ea3] <= bus.req_wdata[31:24];
      end
    end
  end

`ifdef DMEM_FAULT_CNT_EN
  logic [15:0] r_fault_cnt;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_cnt <= 16'h0;
    end else if (w_accept && w_fault && r_fault_cnt != 16'hFFFF) begin
      r_fault_cnt <= r_fault_cnt + 16'h1;
    end
  end

  assign fault_cnt = r_fault_cnt;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: two instances share one requester, selected by sel.
//   u_dut0: BASE_OFFSET=0,   WAIT_CYCLES=1
//   u_dut1: BASE_OFFSET=100, WAIT_CYCLES=0
module tb_dmem_ctrl;
  logic        sclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel = 1'b0;
  logic        t_valid = 1'b0, t_write = 1'b0, t_signed = 1'b0, t_rdy = 1'b0;
  logic [1:0]  t_size = 2'b00;
  logic [9:0]  t_addr = 10'h0;
  logic [31:0] t_wdata = 32'h0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 sclk = ~sclk;

  dmem_ctrl_if #(.ADDR_W(10)) bus0 ();
  dmem_ctrl_if #(.ADDR_W(10)) bus1 ();

  assign bus0.req_valid  = t_valid & ~sel;
  assign bus0.req_write  = t_write;
  assign bus0.req_size   = t_size;
  assign bus0.req_signed = t_signed;
  assign bus0.req_addr   = t_addr;
  assign bus0.req_wdata  = t_wdata;
  assign bus0.rsp_ready  = t_rdy & ~sel;
  assign bus1.req_valid  = t_valid & sel;
  assign bus1.req_write  = t_write;
  assign bus1.req_size   = t_size;
  assign bus1.req_signed = t_signed;
  assign bus1.req_addr   = t_addr;
  assign bus1.req_wdata  = t_wdata;
  assign bus1.rsp_ready  = t_rdy & sel;

  logic        m_req_ready, m_rsp_valid, m_rsp_fault;
  logic [31:0] m_rsp_rdata;
  assign m_req_ready = sel ? bus1.req_ready : bus0.req_ready;
  assign m_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
  assign m_rsp_fault = sel ? bus1.rsp_fault : bus0.rsp_fault;
  assign m_rsp_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;

`ifdef DMEM_FAULT_CNT_EN
  logic [15:0] fc0, fc1;
`endif

  dmem_ctrl #(.ADDR_W(10), .DEPTH_BYTES(1024), .BASE_OFFSET(0), .WAIT_CYCLES(1)) u_dut0 (
    .sclk(sclk), .rst_n(rst_n), .bus(bus0)
`ifdef DMEM_FAULT_CNT_EN
    , .fault_cnt(fc0)
`endif
  );

  dmem_ctrl #(.ADDR_W(10), .DEPTH_BYTES(1024), .BASE_OFFSET(100), .WAIT_CYCLES(0)) u_dut1 (
    .sclk(sclk), .rst_n(rst_n), .bus(bus1)
`ifdef DMEM_FAULT_CNT_EN
    , .fault_cnt(fc1)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One full transaction; lat = edges after acceptance until rsp_valid is seen high.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [9:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic f, output int lat);
    int g;
    @(negedge sclk);
    t_write = w; t_size = sz; t_signed = sg; t_addr = a; t_wdata = wd; t_valid = 1'b1;
    g = 0;
    while (!m_req_ready && g < 50) begin @(negedge sclk); g++; end
    if (g >= 50) check_eq("accept_timeout", 32'd1, 32'd0);
    @(posedge sclk);
    @(negedge sclk);
    t_valid = 1'b0;
    lat = 1;
    while (!m_rsp_valid && lat < 40) begin @(negedge sclk); lat++; end
    if (lat >= 40) check_eq("rsp_timeout", 32'd1, 32'd0);
    rd = m_rsp_rdata;
    f  = m_rsp_fault;
    t_rdy = 1'b1;
    @(negedge sclk);
    t_rdy = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [1:0] sz, input logic sg, input logic [9:0] a,
                    input logic [31:0] exp_d, input logic exp_f);
    logic [31:0] rd; logic f; int lat;
    do_req(1'b0, sz, sg, a, 32'h0, rd, f, lat);
    check_eq({tag, "_data"}, rd, exp_d);
    check_eq({tag, "_fault"}, {31'b0, f}, {31'b0, exp_f});
  endtask

  task automatic st(input string tag, input logic [1:0] sz, input logic [9:0] a,
                    input logic [31:0] wd, input logic exp_f);
    logic [31:0] rd; logic f; int lat;
    do_req(1'b1, sz, 1'b0, a, wd, rd, f, lat);
    check_eq({tag, "_data"}, rd, 32'h0);
    check_eq({tag, "_fault"}, {31'b0, f}, {31'b0, exp_f});
  endtask

  // Only the fault flag matters (array bytes not yet written).
  task automatic ld_fault_only(input string tag, input logic [1:0] sz, input logic [9:0] a,
                               input logic exp_f);
    logic [31:0] rd; logic f; int lat;
    do_req(1'b0, sz, 1'b0, a, 32'h0, rd, f, lat);
    check_eq({tag, "_fault"}, {31'b0, f}, {31'b0, exp_f});
  endtask

  initial begin
    logic [31:0] rd;
    logic        f;
    int          lat;
    int          seen;
    logic [7:0]  exp_b [4];

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req_ready", {31'b0, bus0.req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'b0, bus0.rsp_valid}, 32'd0);
    check_eq("rst_rsp_rdata", bus0.rsp_rdata, 32'h0);
    check_eq("rst_rsp_fault", {31'b0, bus0.rsp_fault}, 32'd0);
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;

    // SW with WAIT_CYCLES=1: response seen 2 edges after acceptance
    do_req(1'b1, 2'b00, 1'b0, 10'h010, 32'h8000_F0A5, rd, f, lat);
    check_eq("sw_lat", 32'(lat), 32'd2);
    check_eq("sw_data", rd, 32'h0);
    check_eq("sw_fault", {31'b0, f}, 32'd0);
    check_eq("sw_idle_ready", {31'b0, m_req_ready}, 32'd1);

    // Little-endian byte placement
    ld("rb10", 2'b10, 1'b0, 10'h010, 32'h0000_00A5, 1'b0);
    ld("rb11", 2'b10, 1'b0, 10'h011, 32'h0000_00F0, 1'b0);
    ld("rb12", 2'b10, 1'b0, 10'h012, 32'h0000_0000, 1'b0);
    ld("rb13", 2'b10, 1'b0, 10'h013, 32'h0000_0080, 1'b0);

    // Sign / zero extension
    ld("lb",   2'b10, 1'b1, 10'h010, 32'hFFFF_FFA5, 1'b0);
    ld("lbu",  2'b10, 1'b0, 10'h010, 32'h0000_00A5, 1'b0);
    ld("lh",   2'b01, 1'b1, 10'h010, 32'hFFFF_F0A5, 1'b0);
    ld("lhu",  2'b01, 1'b0, 10'h010, 32'h0000_F0A5, 1'b0);
    ld("lw",   2'b00, 1'b1, 10'h010, 32'h8000_F0A5, 1'b0);
    ld("lh12", 2'b01, 1'b1, 10'h012, 32'hFFFF_8000, 1'b0);

    // Misalignment and illegal size
    ld("lw_mis", 2'b00, 1'b0, 10'h012, 32'h0, 1'b1);
    st("sh_mis", 2'b01, 10'h011, 32'h0000_BEEF, 1'b1);
    ld("sh_mis_b11", 2'b10, 1'b0, 10'h011, 32'h0000_00F0, 1'b0);
    ld("sh_mis_b12", 2'b10, 1'b0, 10'h012, 32'h0000_0000, 1'b0);
    ld("sz11", 2'b11, 1'b0, 10'h010, 32'h0, 1'b1);

    // Range at the top of the array
    ld("lw_oor", 2'b00, 1'b0, 10'd1022, 32'h0, 1'b1);
    st("sb_top", 2'b10, 10'd1023, 32'h0000_00C3, 1'b0);
    ld("lb_top", 2'b10, 1'b1, 10'd1023, 32'hFFFF_FFC3, 1'b0);
    ld_fault_only("lw_1020", 2'b00, 10'd1020, 1'b0);
    ld_fault_only("lh_1022", 2'b01, 10'd1022, 1'b0);

    // Backpressure: response held, competing request ignored
    st("pre_sw20", 2'b00, 10'h020, 32'h1122_3344, 1'b0);
    @(negedge sclk);
    t_write = 1'b0; t_size = 2'b00; t_signed = 1'b0; t_addr = 10'h010; t_valid = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    t_valid = 1'b0;
    seen = 0;
    while (!m_rsp_valid && seen < 20) begin @(negedge sclk); seen++; end
    t_write = 1'b1; t_addr = 10'h020; t_wdata = 32'hDEAD_BEEF; t_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk);
      check_eq("bp_rsp_valid", {31'b0, m_rsp_valid}, 32'd1);
      check_eq("bp_rsp_rdata", m_rsp_rdata, 32'h8000_F0A5);
      check_eq("bp_req_ready", {31'b0, m_req_ready}, 32'd0);
    end
    t_valid = 1'b0;
    t_rdy = 1'b1;
    @(negedge sclk);
    t_rdy = 1'b0;
    check_eq("bp_rel_rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
    check_eq("bp_rel_req_ready", {31'b0, m_req_ready}, 32'd1);
    ld("bp_w20", 2'b00, 1'b0, 10'h020, 32'h1122_3344, 1'b0);

    // BASE_OFFSET=100, WAIT_CYCLES=0 instance
    sel = 1'b1;
    do_req(1'b1, 2'b00, 1'b0, 10'h000, 32'hA1B2_C3D4, rd, f, lat);
    check_eq("off_lat", 32'(lat), 32'd1);
    check_eq("off_fault", {31'b0, f}, 32'd0);
    exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
    for (int i = 0; i < 4; i++) check_eq("off_byte", {24'h0, u_dut1.r_mem[100 + i]}, {24'h0, exp_b[i]});
    ld("off_lw0", 2'b00, 1'b0, 10'h000, 32'hA1B2_C3D4, 1'b0);
    ld_fault_only("off_lw923", 2'b00, 10'd923, 1'b1);
    ld_fault_only("off_lb923", 2'b10, 10'd923, 1'b0);
    ld_fault_only("off_wrap924", 2'b00, 10'd924, 1'b0);
    ld_fault_only("off_lh1", 2'b01, 10'd1, 1'b1);
    sel = 1'b0;

    // Reset while in WAIT after an accepted store
    @(negedge sclk);
    t_write = 1'b1; t_size = 2'b00; t_addr = 10'h040; t_wdata = 32'h1234_5678; t_valid = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    t_valid = 1'b0;
    rst_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk);
      if (m_rsp_valid) seen++;
    end
    rst_n = 1'b1;
    check_eq("rstw_req_ready", {31'b0, m_req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk);
      if (m_rsp_valid) seen++;
    end
    check_eq("rstw_no_rsp", 32'(seen), 32'd0);
    ld("rstw_lw40", 2'b00, 1'b0, 10'h040, 32'h1234_5678, 1'b0);

`ifdef DMEM_FAULT_CNT_EN
    check_eq("fcnt_zero", {16'h0, fc0}, 32'd0);
    ld("fc_a", 2'b00, 1'b0, 10'h012, 32'h0, 1'b1);
    ld("fc_b", 2'b11, 1'b0, 10'h010, 32'h0, 1'b1);
    ld("fc_c", 2'b00, 1'b0, 10'd1022, 32'h0, 1'b1);
    check_eq("fcnt_three", {16'h0, fc0}, 32'd3);
    @(negedge sclk);
    rst_n = 1'b0;
    @(negedge sclk);
    check_eq("fcnt_reset", {16'h0, fc0}, 32'd0);
    rst_n = 1'b1;
`endif

    repeat (2) @(negedge sclk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
